// File: rtl/lut_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// lut_layer_sequencer_if : config port, input stream and output stream bundle
// Revision: 1.0
// ============================================================================
interface lut_layer_sequencer_if #(
   parameter int N_NEURONS = 8,
   parameter int N_IN      = 8,
   parameter int BW        = 2
);
   localparam int NW = $clog2(N_NEURONS);

   logic                    cfg_we;
   logic                    cfg_sel;
   logic [NW-1:0]           cfg_neuron;
   logic [7:0]              cfg_addr;
   logic [7:0]              cfg_wdata;
   logic                    cfg_busy;

   logic                    in_valid;
   logic                    in_ready;
   logic [N_IN*BW-1:0]      in_data;

   logic                    out_valid;
   logic                    out_ready;
   logic [N_NEURONS*BW-1:0] out_data;

   modport master (
      output cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_wdata,
      output in_valid, in_data, out_ready,
      input  cfg_busy, in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_wdata,
      input  in_valid, in_data, out_ready,
      output cfg_busy, in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/lut_layer_sequencer.sv
`default_nettype none
// ============================================================================
// lut_layer_sequencer : one-neuron-per-cycle LogicNets layer over a shared table RAM
// Revision: 1.0
// ============================================================================
module lut_layer_sequencer #(
   parameter int N_NEURONS = 8,
   parameter int N_IN      = 8,
   parameter int FANIN     = 4,
   parameter int BW        = 2
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   lut_layer_sequencer_if.slave bus
);
   localparam int NW    = $clog2(N_NEURONS);
   localparam int IW    = $clog2(N_IN);
   localparam int CW    = NW + 1;
   localparam int AW    = FANIN * BW;
   localparam int DEPTH = N_NEURONS * (1 << AW);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [N_IN*BW-1:0]      feat_q, feat_d;
   logic [IW-1:0]           conn_q [N_NEURONS][FANIN];
   logic [IW-1:0]           conn_d [N_NEURONS][FANIN];
   logic [N_NEURONS*BW-1:0] out_data_q, out_data_d;
   logic                    rd_vld_q, rd_vld_d;
   logic [NW-1:0]           rd_idx_q, rd_idx_d;
   logic [BW-1:0]           rd_data_q;
   logic [BW-1:0]           tbl_mem [DEPTH];

   logic                    hs_in;
   logic                    cfg_ok;
   logic                    issue;
   logic [NW-1:0]           cur_neuron;
   logic [AW-1:0]           lut_addr;
   logic [NW+AW-1:0]        rd_addr;
   logic                    unused_cfg_bits;

   assign unused_cfg_bits = ^bus.cfg_wdata;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The counter MSB flags "all neurons issued"; the last read lands on that same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.in_valid)    state_d = S_EVAL;
         S_EVAL:  if (cnt_q[CW-1])     state_d = S_OUT;
         S_OUT:   if (bus.out_ready)   state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.cfg_busy  = 1'b1;
      case (state_q)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            bus.cfg_busy = 1'b0;
         end
         S_OUT:   bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      hs_in      = (state_q == S_IDLE) && bus.in_valid;
      cfg_ok     = (state_q == S_IDLE) && bus.cfg_we;
      issue      = (state_q == S_EVAL) && !cnt_q[CW-1];
      cur_neuron = cnt_q[NW-1:0];

      feat_d = hs_in ? bus.in_data : feat_q;

      cnt_d = cnt_q;
      if (hs_in) begin
         cnt_d = '0;
      end else if (issue) begin
         cnt_d = cnt_q + CW'(1);
      end

      conn_d = conn_q;
      if (cfg_ok && bus.cfg_sel) begin
         conn_d[bus.cfg_neuron][bus.cfg_addr[1:0]] = bus.cfg_wdata[IW-1:0];
      end

      // Slot 0 feeds the LSBs of the table address.
      lut_addr = '0;
      for (int j = 0; j < FANIN; j++) begin
         for (int k = 0; k < N_IN; k++) begin
            if (conn_q[cur_neuron][j] == IW'(k)) begin
               lut_addr[j*BW +: BW] = feat_q[k*BW +: BW];
            end
         end
      end
      rd_addr = {cur_neuron, lut_addr};

      rd_vld_d = issue;
      rd_idx_d = cur_neuron;

      out_data_d = out_data_q;
      for (int n = 0; n < N_NEURONS; n++) begin
         if (rd_vld_q && (rd_idx_q == NW'(n))) begin
            out_data_d[n*BW +: BW] = rd_data_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         feat_q     <= '0;
         out_data_q <= '0;
         rd_vld_q   <= 1'b0;
         rd_idx_q   <= '0;
         for (int n = 0; n < N_NEURONS; n++) begin
            for (int j = 0; j < FANIN; j++) begin
               conn_q[n][j] <= IW'((n * FANIN + j) % N_IN);
            end
         end
      end else begin
         cnt_q      <= cnt_d;
         feat_q     <= feat_d;
         out_data_q <= out_data_d;
         rd_vld_q   <= rd_vld_d;
         rd_idx_q   <= rd_idx_d;
         conn_q     <= conn_d;
      end
   end

   // Table RAM has no reset so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (cfg_ok && !bus.cfg_sel) begin
         tbl_mem[{bus.cfg_neuron, bus.cfg_addr[AW-1:0]}] <= bus.cfg_wdata[BW-1:0];
      end
      rd_data_q <= tbl_mem[rd_addr];
   end

   assign bus.out_data = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lut_layer_sequencer : directed + randomized checks against an array-based layer model
// Revision: 1.0
// ============================================================================
module tb_lut_layer_sequencer;
   localparam int NN = 8;
   localparam int NI = 8;
   localparam int FI = 4;
   localparam int BW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic [1:0] tbl_m  [NN][256];
   int         conn_m [NN][FI];

   lut_layer_sequencer_if #(.N_NEURONS(NN), .N_IN(NI), .BW(BW)) bus ();

   lut_layer_sequencer #(
      .N_NEURONS (NN),
      .N_IN      (NI),
      .FANIN     (FI),
      .BW        (BW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void conn_reset_model();
      for (int n = 0; n < NN; n++)
         for (int j = 0; j < FI; j++)
            conn_m[n][j] = (n * FI + j) % NI;
   endfunction

   // Each neuron: gather its four chosen features into an address, look it up.
   function automatic logic [NN*BW-1:0] model(input logic [NI*BW-1:0] f);
      logic [NN*BW-1:0] r;
      logic [7:0]       a;
      r = '0;
      for (int n = 0; n < NN; n++) begin
         a = '0;
         for (int j = 0; j < FI; j++)
            a[j*BW +: BW] = f[conn_m[n][j]*BW +: BW];
         r[n*BW +: BW] = tbl_m[n][a];
      end
      return r;
   endfunction

   task automatic cfg_wr(input bit sel, input int n, input int addr, input int data);
      bus.cfg_we     = 1'b1;
      bus.cfg_sel    = sel;
      bus.cfg_neuron = 3'(n);
      bus.cfg_addr   = 8'(addr);
      bus.cfg_wdata  = 8'(data);
      step();
      bus.cfg_we = 1'b0;
      if (sel) conn_m[n][addr % FI] = data % NI;
      else     tbl_m[n][addr] = 2'(data);
   endtask

   task automatic start(input logic [NI*BW-1:0] f);
      int w;
      w = 0;
      bus.in_data  = f;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && w < 64) begin step(); w++; end
      chk("in_ready_before_hs", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic finish(output logic [NN*BW-1:0] got, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 64) begin step(); lat++; end
      chk("out_valid_seen", bus.out_valid, 1);
      got = bus.out_data;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [NI*BW-1:0] f;
      logic [NN*BW-1:0] got, expv;
      int lat, cyc, prev_hs, w;

      bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_neuron = '0;
      bus.cfg_addr = '0; bus.cfg_wdata = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      conn_reset_model();

      #12;
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data",  bus.out_data, 0);
      chk("rst_in_ready",  bus.in_ready, 1);
      chk("rst_cfg_busy",  bus.cfg_busy, 0);

      // Directed: neuron 3 table = a[1:0], default wiring puts feature 4 in slot 0.
      for (int n = 0; n < NN; n++)
         for (int a = 0; a < 256; a++) cfg_wr(1'b0, n, a, int'($urandom_range(0, 3)));
      for (int a = 0; a < 256; a++) cfg_wr(1'b0, 3, a, a % 4);
      f = '0; f[9:8] = 2'b11;
      start(f); finish(got, lat);
      chk("t1_latency", lat, 9);
      chk("t1_neuron3", got[7:6], 2'b11);
      chk("t1_all", got, model(f));

      // Directed: tables = a[7:6], neuron 0 slot 3 rewired to feature 7.
      for (int n = 0; n < NN; n++)
         for (int a = 0; a < 256; a++) cfg_wr(1'b0, n, a, a >> 6);
      cfg_wr(1'b1, 0, 3, 7);
      f = '0; f[15:14] = 2'b10;
      start(f); finish(got, lat);
      chk("t2_neuron0", got[1:0], 2'b10);
      chk("t2_all", got, model(f));

      start(f); step(); step();
      chk("t2_busy_in_eval", bus.cfg_busy, 1);
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_neuron = 3'd0;
      bus.cfg_addr = 8'd3; bus.cfg_wdata = 8'd0;
      step();
      bus.cfg_we = 1'b0;
      finish(got, lat);
      chk("t2_evalwr_neuron0", got[1:0], 2'b10);
      start(f); finish(got, lat);
      chk("t2_evalwr_after", got, model(f));

      // Random tables and wiring.
      for (int n = 0; n < NN; n++)
         for (int a = 0; a < 256; a++) cfg_wr(1'b0, n, a, int'($urandom_range(0, 3)));
      for (int n = 0; n < NN; n++)
         for (int j = 0; j < FI; j++) cfg_wr(1'b1, n, j, int'($urandom_range(0, NI - 1)));

      // Backpressure: 20 stalled cycles.
      f = 16'($urandom);
      expv = model(f);
      start(f);
      w = 0;
      while (!bus.out_valid && w < 64) begin step(); w++; end
      chk("bp_valid_rise", bus.out_valid, 1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_data", bus.out_data, expv);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("bp_release_in_ready", bus.in_ready, 1);

      // Back-to-back streaming with in_valid and out_ready held high.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'($urandom);
      cyc = 0;
      prev_hs = 0;
      for (int i = 0; i < 6; i++) begin
         w = 0;
         while (!bus.in_ready && w < 64) begin step(); cyc++; w++; end
         chk("b2b_in_ready", bus.in_ready, 1);
         if (i > 0) chk("b2b_interval", cyc - prev_hs, 11);
         prev_hs = cyc;
         expv = model(bus.in_data);
         step(); cyc++;
         bus.in_data = 16'($urandom);
         w = 0;
         while (!bus.out_valid && w < 64) begin step(); cyc++; w++; end
         chk("b2b_valid", bus.out_valid, 1);
         chk("b2b_data", bus.out_data, expv);
         step(); cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      // Reset in the middle of an evaluation; tables must survive.
      f = 16'($urandom);
      start(f);
      step(); step(); step(); step();
      rst_n = 1'b0;
      #1;
      chk("rstmid_out_valid", bus.out_valid, 0);
      chk("rstmid_out_data",  bus.out_data, 0);
      chk("rstmid_in_ready",  bus.in_ready, 1);
      chk("rstmid_cfg_busy",  bus.cfg_busy, 0);
      conn_reset_model();
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("rstpost_out_data",  bus.out_data, 0);
      chk("rstpost_out_valid", bus.out_valid, 0);
      chk("rstpost_in_ready",  bus.in_ready, 1);
      start(f); finish(got, lat);
      chk("rstmid_rerun", got, model(f));

      // Config write and input handshake in the same IDLE cycle.
      chk("same_cycle_ready", bus.in_ready, 1);
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_neuron = 3'd0;
      bus.cfg_addr = 8'd0; bus.cfg_wdata = 8'd1;
      bus.in_valid = 1'b1; bus.in_data = '0;
      step();
      bus.cfg_we = 1'b0;
      bus.in_valid = 1'b0;
      tbl_m[0][0] = 2'b01;
      finish(got, lat);
      chk("same_cycle_latency", lat, 9);
      chk("same_cycle_neuron0", got[1:0], 2'b01);
      chk("same_cycle_all", got, model('0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
